// File: rtl/snitch_fpu_shared_arb.sv
// -----------------------------------------------------------------------------
// snitch_fpu_shared_arb
//
// Front-end that lets NumPorts requesters share a single FPU instance.
// Requests are arbitrated round-robin. The FPU-side tag is {port index, tag},
// and each port may have at most MaxOutstanding accepted ops that have not yet
// been returned. Every FPU response is routed back to the port named in its
// tag MSBs, either through a one-entry register per port (RegisterRsp=1) or
// combinationally (RegisterRsp=0). The payloads are opaque to this block.
//
// Handshake semantics (all interfaces): a transfer happens on a rising clock
// edge where valid && ready. Once valid is raised, it stays high and the
// payload stays stable until that transfer. Ready may depend on valid.
//
// Ports
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   req_data_i/tag_i     per-port request payload and tag (flattened, port 0 in LSBs)
//   req_valid_i/ready_o  per-port request handshake
//   fpu_req_*            granted request toward the FPU, tag = {index, tag}
//   fpu_rsp_*            response from the FPU, tag = {index, tag}
//   rsp_data_o/tag_o     per-port response payload and original tag (flattened)
//   rsp_valid_o/ready_i  per-port response handshake
//   busy_o               some port has an op in flight or a response held
//   err_o                sticky: a response arrived with an index >= NumPorts
// -----------------------------------------------------------------------------
module snitch_fpu_shared_arb #(
   parameter int unsigned NumPorts       = 2,
   parameter int unsigned ReqWidth       = 213,
   parameter int unsigned RspWidth       = 69,
   parameter int unsigned TagWidth       = 7,
   parameter int unsigned MaxOutstanding = 4,
   parameter bit          RegisterRsp    = 1'b1,
   localparam int unsigned IdxW          = (NumPorts > 1) ? $clog2(NumPorts) : 1
) (
   input  logic                         clk_i,
   input  logic                         rst_ni,
   input  logic [NumPorts*ReqWidth-1:0] req_data_i,
   input  logic [NumPorts*TagWidth-1:0] req_tag_i,
   input  logic [NumPorts-1:0]          req_valid_i,
   output logic [NumPorts-1:0]          req_ready_o,
   output logic [ReqWidth-1:0]          fpu_req_data_o,
   output logic [TagWidth+IdxW-1:0]     fpu_req_tag_o,
   output logic                         fpu_req_valid_o,
   input  logic                         fpu_req_ready_i,
   input  logic [RspWidth-1:0]          fpu_rsp_data_i,
   input  logic [TagWidth+IdxW-1:0]     fpu_rsp_tag_i,
   input  logic                         fpu_rsp_valid_i,
   output logic                         fpu_rsp_ready_o,
   output logic [NumPorts*RspWidth-1:0] rsp_data_o,
   output logic [NumPorts*TagWidth-1:0] rsp_tag_o,
   output logic [NumPorts-1:0]          rsp_valid_o,
   input  logic [NumPorts-1:0]          rsp_ready_i,
   output logic                         busy_o,
   output logic                         err_o
);

   localparam int unsigned FpuTagW = TagWidth + IdxW;
   localparam int unsigned CntW    = $clog2(MaxOutstanding + 1);
   localparam logic [CntW-1:0] CntMax = CntW'(MaxOutstanding);

   // ---------------------------------------------------------------------------
   // Arbitration state
   // ---------------------------------------------------------------------------
   logic [IdxW-1:0]                rr_ptr_q;
   logic [IdxW-1:0]                rr_ptr_next;
   logic                           lock_q;
   logic [IdxW-1:0]                lock_idx_q;
   logic [NumPorts-1:0][CntW-1:0]  cnt_q;

   logic [NumPorts-1:0]            eligible;
   logic [NumPorts-1:0]            upper;
   logic [NumPorts-1:0]            search;
   logic [IdxW-1:0]                pick_idx;
   logic                           pick_valid;
   logic [IdxW-1:0]                gnt_idx;
   logic                           gnt_valid;
   logic                           sel_valid;
   logic [TagWidth-1:0]            sel_tag;
   logic                           req_accept;

   // A port may compete only while it has room for another in-flight op.
   always_comb begin
      eligible = '0;
      for (int p = 0; p < NumPorts; p++) begin
         eligible[p] = req_valid_i[p] && (cnt_q[p] < CntMax);
      end
   end

   // Round-robin pick: prefer eligible ports at or above the pointer; if none,
   // wrap around to the lowest eligible port.
   always_comb begin
      upper = '0;
      for (int p = 0; p < NumPorts; p++) begin
         upper[p] = eligible[p] && (IdxW'(p) >= rr_ptr_q);
      end
      search     = (|upper) ? upper : eligible;
      pick_idx   = '0;
      pick_valid = 1'b0;
      for (int p = NumPorts - 1; p >= 0; p--) begin
         if (search[p]) begin
            pick_idx   = IdxW'(p);
            pick_valid = 1'b1;
         end
      end
   end

   // A request that was offered but not taken keeps its grant so valid and
   // payload toward the FPU stay stable until the FPU accepts.
   assign gnt_idx = lock_q ? lock_idx_q : pick_idx;

   always_comb begin
      fpu_req_data_o = '0;
      sel_tag        = '0;
      sel_valid      = 1'b0;
      for (int p = 0; p < NumPorts; p++) begin
         if (gnt_idx == IdxW'(p)) begin
            fpu_req_data_o = req_data_i[p*ReqWidth +: ReqWidth];
            sel_tag        = req_tag_i[p*TagWidth +: TagWidth];
            sel_valid      = req_valid_i[p];
         end
      end
   end

   assign gnt_valid       = lock_q ? sel_valid : pick_valid;
   assign fpu_req_valid_o = gnt_valid;
   assign fpu_req_tag_o   = {gnt_idx, sel_tag};
   assign req_accept      = gnt_valid && fpu_req_ready_i;

   always_comb begin
      req_ready_o = '0;
      for (int p = 0; p < NumPorts; p++) begin
         req_ready_o[p] = gnt_valid && fpu_req_ready_i && (gnt_idx == IdxW'(p));
      end
   end

   assign rr_ptr_next = (32'(gnt_idx) == NumPorts - 1) ? '0 : gnt_idx + IdxW'(1);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rr_ptr_q   <= '0;
         lock_q     <= 1'b0;
         lock_idx_q <= '0;
      end else begin
         lock_q     <= gnt_valid && !fpu_req_ready_i;
         lock_idx_q <= gnt_idx;
         if (req_accept) begin
            rr_ptr_q <= rr_ptr_next;
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Response demultiplexing
   // ---------------------------------------------------------------------------
   logic [IdxW-1:0]      rsp_idx;
   logic                 rsp_idx_ok;
   logic [TagWidth-1:0]  rsp_tag_strip;
   logic [NumPorts-1:0]  rsp_hit;
   logic [NumPorts-1:0]  stage_ready;
   logic [NumPorts-1:0]  rsp_fire;
   logic                 err_q;

   assign rsp_idx       = fpu_rsp_tag_i[FpuTagW-1 -: IdxW];
   assign rsp_tag_strip = fpu_rsp_tag_i[TagWidth-1:0];
   assign rsp_idx_ok    = (32'(rsp_idx) < NumPorts);

   always_comb begin
      rsp_hit = '0;
      for (int p = 0; p < NumPorts; p++) begin
         rsp_hit[p] = fpu_rsp_valid_i && (rsp_idx == IdxW'(p));
      end
   end

   // An index that names no port matches nothing, so ready stays 1 and the
   // response is swallowed instead of stalling the FPU forever.
   always_comb begin
      fpu_rsp_ready_o = 1'b1;
      for (int p = 0; p < NumPorts; p++) begin
         if (rsp_idx == IdxW'(p)) begin
            fpu_rsp_ready_o = stage_ready[p];
         end
      end
   end

   if (RegisterRsp) begin : g_rsp_reg
      logic [NumPorts-1:0]               valid_q;
      logic [NumPorts-1:0][RspWidth-1:0] data_q;
      logic [NumPorts-1:0][TagWidth-1:0] tag_q;

      // The stage takes a new entry when empty or when its current entry
      // leaves in the same cycle, so a draining port sustains full rate.
      assign stage_ready = ~valid_q | rsp_ready_i;

      always_ff @(posedge clk_i or negedge rst_ni) begin
         if (!rst_ni) begin
            valid_q <= '0;
            data_q  <= '0;
            tag_q   <= '0;
         end else begin
            for (int p = 0; p < NumPorts; p++) begin
               if (rsp_hit[p] && stage_ready[p]) begin
                  valid_q[p] <= 1'b1;
                  data_q[p]  <= fpu_rsp_data_i;
                  tag_q[p]   <= rsp_tag_strip;
               end else if (rsp_ready_i[p]) begin
                  valid_q[p] <= 1'b0;
               end
            end
         end
      end

      assign rsp_valid_o = valid_q;
      assign rsp_data_o  = data_q;
      assign rsp_tag_o   = tag_q;
   end else begin : g_rsp_comb
      assign stage_ready = rsp_ready_i;
      assign rsp_valid_o = rsp_hit;
      assign rsp_data_o  = {NumPorts{fpu_rsp_data_i}};
      assign rsp_tag_o   = {NumPorts{rsp_tag_strip}};
   end

   assign rsp_fire = rsp_valid_o & rsp_ready_i;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         err_q <= 1'b0;
      end else if (fpu_rsp_valid_i && !rsp_idx_ok) begin
         err_q <= 1'b1;
      end
   end

   assign err_o = err_q;

   // ---------------------------------------------------------------------------
   // Per-port in-flight counters. A count covers an op from FPU acceptance
   // until its response leaves the port, including time spent held in the
   // response stage. The zero guard keeps a stray response from wrapping it.
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else begin
         for (int p = 0; p < NumPorts; p++) begin
            if (req_ready_o[p] && !(rsp_fire[p] && (cnt_q[p] != '0))) begin
               cnt_q[p] <= cnt_q[p] + CntW'(1);
            end else if (!req_ready_o[p] && rsp_fire[p] && (cnt_q[p] != '0)) begin
               cnt_q[p] <= cnt_q[p] - CntW'(1);
            end
         end
      end
   end

   assign busy_o = |cnt_q;

endmodule

// File: tb/tb_snitch_fpu_shared_arb.sv
// -----------------------------------------------------------------------------
// tb_snitch_fpu_shared_arb
//
// Random traffic from two ports into the shared arbiter. A small behavioural
// FPU in the bench accepts requests and returns them out of order. A reference
// model tracks the round-robin order, the in-flight counts and the expected
// responses per port. A separate monitor pops the per-port expected queues
// whenever a port hands a response back. A second instance with three ports
// exercises the out-of-range index error and the stripping of the index bits.
// -----------------------------------------------------------------------------
module tb_snitch_fpu_shared_arb;

   localparam int RW = 213;
   localparam int SW = 69;
   localparam int TW = 7;
   localparam int MAXO = 4;

   logic              clk_i;
   logic              rst_ni;
   logic [2*RW-1:0]   req_data_i;
   logic [2*TW-1:0]   req_tag_i;
   logic [1:0]        req_valid_i;
   logic [1:0]        req_ready_o;
   logic [RW-1:0]     fpu_req_data_o;
   logic [TW:0]       fpu_req_tag_o;
   logic              fpu_req_valid_o;
   logic              fpu_req_ready_i;
   logic [SW-1:0]     fpu_rsp_data_i;
   logic [TW:0]       fpu_rsp_tag_i;
   logic              fpu_rsp_valid_i;
   logic              fpu_rsp_ready_o;
   logic [2*SW-1:0]   rsp_data_o;
   logic [2*TW-1:0]   rsp_tag_o;
   logic [1:0]        rsp_valid_o;
   logic [1:0]        rsp_ready_i;
   logic              busy_o;
   logic              err_o;

   // three-port instance
   logic [23:0]  r3_req_data;
   logic [11:0]  r3_req_tag;
   logic [2:0]   r3_req_valid;
   logic [2:0]   r3_req_ready;
   logic [7:0]   f3_req_data;
   logic [5:0]   f3_req_tag;
   logic         f3_req_valid;
   logic         f3_req_ready;
   logic [7:0]   f3_rsp_data;
   logic [5:0]   f3_rsp_tag;
   logic         f3_rsp_valid;
   logic         f3_rsp_ready;
   logic [23:0]  r3_rsp_data;
   logic [11:0]  r3_rsp_tag;
   logic [2:0]   r3_rsp_valid;
   logic [2:0]   r3_rsp_ready;
   logic         busy3;
   logic         err3;

   snitch_fpu_shared_arb #(
      .NumPorts(2), .ReqWidth(RW), .RspWidth(SW), .TagWidth(TW),
      .MaxOutstanding(MAXO), .RegisterRsp(1'b1)
   ) dut (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .req_data_i(req_data_i), .req_tag_i(req_tag_i),
      .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
      .fpu_req_data_o(fpu_req_data_o), .fpu_req_tag_o(fpu_req_tag_o),
      .fpu_req_valid_o(fpu_req_valid_o), .fpu_req_ready_i(fpu_req_ready_i),
      .fpu_rsp_data_i(fpu_rsp_data_i), .fpu_rsp_tag_i(fpu_rsp_tag_i),
      .fpu_rsp_valid_i(fpu_rsp_valid_i), .fpu_rsp_ready_o(fpu_rsp_ready_o),
      .rsp_data_o(rsp_data_o), .rsp_tag_o(rsp_tag_o),
      .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
      .busy_o(busy_o), .err_o(err_o)
   );

   snitch_fpu_shared_arb #(
      .NumPorts(3), .ReqWidth(8), .RspWidth(8), .TagWidth(4),
      .MaxOutstanding(2), .RegisterRsp(1'b1)
   ) dut3 (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .req_data_i(r3_req_data), .req_tag_i(r3_req_tag),
      .req_valid_i(r3_req_valid), .req_ready_o(r3_req_ready),
      .fpu_req_data_o(f3_req_data), .fpu_req_tag_o(f3_req_tag),
      .fpu_req_valid_o(f3_req_valid), .fpu_req_ready_i(f3_req_ready),
      .fpu_rsp_data_i(f3_rsp_data), .fpu_rsp_tag_i(f3_rsp_tag),
      .fpu_rsp_valid_i(f3_rsp_valid), .fpu_rsp_ready_o(f3_rsp_ready),
      .rsp_data_o(r3_rsp_data), .rsp_tag_o(r3_rsp_tag),
      .rsp_valid_o(r3_rsp_valid), .rsp_ready_i(r3_rsp_ready),
      .busy_o(busy3), .err_o(err3)
   );

   // ---------------------------------------------------------------------------
   // Clock
   // ---------------------------------------------------------------------------
   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   // ---------------------------------------------------------------------------
   // Reference model state and scoreboard
   // ---------------------------------------------------------------------------
   int checks = 0;
   int errors = 0;

   int          cnt_m [2];       // accepted but not yet handed back, per port
   int          next_m;          // port the round-robin scan starts from
   bit          held_m;          // last offer was refused, same port must repeat
   int          held_port_m;
   bit          pact [2];        // port has a request on offer
   logic [RW-1:0] pdata [2];
   logic [TW-1:0] ptag [2];
   logic [TW:0] fpu_q [$];       // requests inside the behavioural FPU
   bit          rsp_taken;
   logic [SW+TW-1:0] exp_q0 [$];  // {data, tag} expected on port 0
   logic [SW+TW-1:0] exp_q1 [$];  // {data, tag} expected on port 1

   task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [RW-1:0] rand_req();
      logic [RW-1:0] r;
      r = '0;
      for (int i = 0; i < 7; i++) r = (r << 32) | RW'($urandom);
      return r;
   endfunction

   // One clock of traffic. Percent knobs: pv new request, pfr FPU request
   // ready, prs FPU produces a response, prr port response ready.
   task automatic step(input int pv, input int pfr, input int prs, input int prr);
      int          g;
      bit          gv;
      int          ri;
      bit          exp_rdy;
      bit          fire;
      logic [1:0]  exp_rr;
      logic [TW:0] exp_tag;
      @(negedge clk_i);
      if (rsp_taken) begin
         fpu_rsp_valid_i = 1'b0;
         rsp_taken = 1'b0;
      end
      for (int p = 0; p < 2; p++) begin
         if (!pact[p] && $urandom_range(99) < pv) begin
            pact[p]  = 1'b1;
            pdata[p] = rand_req();
            ptag[p]  = TW'($urandom);
         end
         req_valid_i[p]             = pact[p];
         req_data_i[p*RW +: RW]     = pdata[p];
         req_tag_i[p*TW +: TW]      = ptag[p];
         rsp_ready_i[p]             = ($urandom_range(99) < prr);
      end
      fpu_req_ready_i = ($urandom_range(99) < pfr);
      if (!fpu_rsp_valid_i && fpu_q.size() > 0 && $urandom_range(99) < prs) begin
         ri = $urandom_range(fpu_q.size() - 1);
         fpu_rsp_tag_i   = fpu_q[ri];
         fpu_q.delete(ri);
         fpu_rsp_data_i  = {5'($urandom), $urandom, $urandom};
         fpu_rsp_valid_i = 1'b1;
      end
      #1;
      // Expected grant: a refused offer repeats; otherwise scan from next_m
      // for the first port with a request and fewer than MAXO in flight.
      gv = 1'b0;
      g  = 0;
      if (held_m) begin
         gv = 1'b1;
         g  = held_port_m;
      end else begin
         for (int k = 0; k < 2; k++) begin
            int c;
            c = (next_m + k) % 2;
            if (!gv && pact[c] && cnt_m[c] < MAXO) begin
               gv = 1'b1;
               g  = c;
            end
         end
      end
      check("busy", busy_o, (cnt_m[0] + cnt_m[1]) != 0);
      check("fpu_req_valid", fpu_req_valid_o, gv);
      exp_rr = 2'b00;
      if (gv && fpu_req_ready_i) exp_rr[g] = 1'b1;
      check("req_ready", req_ready_o, exp_rr);
      if (gv) begin
         exp_tag = {1'(g), ptag[g]};
         check("fpu_req_tag", fpu_req_tag_o, exp_tag);
         check("fpu_req_data", fpu_req_data_o, pdata[g]);
      end
      held_m      = gv && !fpu_req_ready_i;
      held_port_m = g;
      if (gv && fpu_req_ready_i) begin
         fpu_q.push_back({1'(g), ptag[g]});
         cnt_m[g]++;
         next_m  = (g + 1) % 2;
         pact[g] = 1'b0;
      end
      fire = 1'b0;
      ri   = 0;
      if (fpu_rsp_valid_i) begin
         ri = int'(fpu_rsp_tag_i[TW]);
         exp_rdy = ((ri == 0) ? (exp_q0.size() == 0) : (exp_q1.size() == 0)) || rsp_ready_i[ri];
         check("fpu_rsp_ready", fpu_rsp_ready_o, exp_rdy);
         fire = fpu_rsp_ready_o;
      end
      #2;  // after the monitor has retired this cycle's departures
      if (fire) begin
         if (ri == 0) exp_q0.push_back({fpu_rsp_data_i, fpu_rsp_tag_i[TW-1:0]});
         else         exp_q1.push_back({fpu_rsp_data_i, fpu_rsp_tag_i[TW-1:0]});
         rsp_taken = 1'b1;
      end
   endtask

   // ---------------------------------------------------------------------------
   // Monitor: compares every presented port response with the scoreboard
   // ---------------------------------------------------------------------------
   initial begin
      forever begin
         @(negedge clk_i);
         #2;
         for (int p = 0; p < 2; p++) begin
            int sz;
            logic [SW+TW-1:0] e;
            sz = (p == 0) ? exp_q0.size() : exp_q1.size();
            check($sformatf("rsp_valid%0d", p), rsp_valid_o[p], sz > 0);
            if (rsp_valid_o[p] && sz > 0) begin
               e = (p == 0) ? exp_q0[0] : exp_q1[0];
               check($sformatf("rsp_data%0d", p), rsp_data_o[p*SW +: SW], e[SW+TW-1:TW]);
               check($sformatf("rsp_tag%0d", p), rsp_tag_o[p*TW +: TW], e[TW-1:0]);
               if (rsp_ready_i[p]) begin
                  if (p == 0) void'(exp_q0.pop_front());
                  else        void'(exp_q1.pop_front());
                  if (cnt_m[p] > 0) cnt_m[p]--;
               end
            end
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Main sequence
   // ---------------------------------------------------------------------------
   initial begin
      int n;
      rst_ni          = 1'b0;
      req_data_i      = '0;
      req_tag_i       = '0;
      req_valid_i     = '0;
      fpu_req_ready_i = 1'b0;
      fpu_rsp_data_i  = '0;
      fpu_rsp_tag_i   = '0;
      fpu_rsp_valid_i = 1'b0;
      rsp_ready_i     = '0;
      r3_req_data     = '0;
      r3_req_tag      = '0;
      r3_req_valid    = '0;
      f3_req_ready    = 1'b1;
      f3_rsp_data     = '0;
      f3_rsp_tag      = '0;
      f3_rsp_valid    = 1'b0;
      r3_rsp_ready    = 3'b111;
      cnt_m[0] = 0;
      cnt_m[1] = 0;
      next_m = 0;
      held_m = 1'b0;
      held_port_m = 0;
      pact[0] = 1'b0;
      pact[1] = 1'b0;
      pdata[0] = '0;
      pdata[1] = '0;
      ptag[0] = '0;
      ptag[1] = '0;
      rsp_taken = 1'b0;

      repeat (3) @(negedge clk_i);
      check("rst_busy", busy_o, 1'b0);
      check("rst_err", err_o, 1'b0);
      check("rst_rsp_valid", rsp_valid_o, 2'b00);
      check("rst_fpu_req_valid", fpu_req_valid_o, 1'b0);
      check("rst_err3", err3, 1'b0);
      rst_ni = 1'b1;

      // Balanced traffic, then slow FPU (saturates the in-flight limit), then
      // heavy port back-pressure.
      for (int c = 0; c < 500; c++) step(70, 80, 60, 80);
      for (int c = 0; c < 500; c++) step(90, 90, 10, 90);
      for (int c = 0; c < 500; c++) step(80, 70, 70, 30);

      n = 0;
      while ((fpu_q.size() > 0 || fpu_rsp_valid_i || exp_q0.size() > 0 || exp_q1.size() > 0 ||
              pact[0] || pact[1]) && n < 400) begin
         step(0, 100, 100, 100);
         n++;
      end
      if (n >= 400) begin
         checks++;
         errors++;
         $display("FAIL drain_timeout actual=%0d cycles expected below 400", n);
      end
      @(negedge clk_i);
      #1;
      check("drain_busy", busy_o, 1'b0);

      // Out-of-range index on the three-port instance is swallowed and flagged.
      @(negedge clk_i);
      f3_rsp_tag   = {2'd3, 4'h5};
      f3_rsp_data  = 8'h3C;
      f3_rsp_valid = 1'b1;
      #1;
      check("bad_idx_ready", f3_rsp_ready, 1'b1);
      check("bad_idx_err_before", err3, 1'b0);
      @(negedge clk_i);
      f3_rsp_tag  = {2'd2, 4'h9};
      f3_rsp_data = 8'hA5;
      #1;
      check("bad_idx_err", err3, 1'b1);
      check("bad_idx_no_valid", r3_rsp_valid, 3'b000);
      check("p2_rsp_ready", f3_rsp_ready, 1'b1);
      @(negedge clk_i);
      f3_rsp_valid = 1'b0;
      #1;
      check("p2_rsp_valid", r3_rsp_valid, 3'b100);
      check("p2_rsp_tag", r3_rsp_tag[11:8], 4'h9);
      check("p2_rsp_data", r3_rsp_data[23:16], 8'hA5);
      check("err_sticky", err3, 1'b1);
      @(negedge clk_i);
      #1;
      check("p2_rsp_drained", r3_rsp_valid, 3'b000);
      check("err_still_sticky", err3, 1'b1);
      check("busy3_idle", busy3, 1'b0);

      // Reset clears the sticky error.
      @(negedge clk_i);
      rst_ni = 1'b0;
      #1;
      check("reset_err3", err3, 1'b0);
      check("reset_busy", busy_o, 1'b0);
      check("reset_rsp_valid", rsp_valid_o, 2'b00);
      @(negedge clk_i);
      rst_ni = 1'b1;
      @(negedge clk_i);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
